// File: rtl/exe_mem_sram_controller.sv
// EXE/MEM to 16-bit SRAM bridge: each 32-bit load/store runs as a LOW then HIGH
// half-word phase while ready is held low to freeze the pipeline.
module exe_mem_sram_controller #(
  parameter int ADDRESS_LEN   = 32,
  parameter int REGISTER_LEN  = 32,
  parameter int SRAM_ADDR_LEN = 18,
  parameter int MEM_BASE      = 1024,
  parameter int WAIT_CYCLES   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic                     wr_en,
  input  logic [ADDRESS_LEN-1:0]   address,
  input  logic [REGISTER_LEN-1:0]  write_data,
  output logic [REGISTER_LEN-1:0]  read_data,
  output logic                     ready,
  inout  wire  [15:0]              sram_dq,
  output logic [SRAM_ADDR_LEN-1:0] sram_addr,
  output logic                     sram_we_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  state_t                   state, state_n;
  logic [CNT_W-1:0]         counter, counter_n;
  logic                     cmd_wr;
  logic [SRAM_ADDR_LEN-2:0] widx_q;
  logic [REGISTER_LEN-1:0]  wdata_q;
  logic [15:0]              lo;
  logic [ADDRESS_LEN-1:0]   offset;
  logic                     last_cycle;
  logic                     request;
  logic                     active;
  logic [15:0]              dq_out;
  logic                     addr_unused;

  assign request    = rd_en | wr_en;
  assign last_cycle = (counter == CNT_W'(WAIT_CYCLES));
  assign offset     = address - ADDRESS_LEN'(MEM_BASE);
  // Byte lane bits and word-index bits beyond the SRAM range are dropped (address wraps).
  assign addr_unused = ^{offset[1:0], offset[ADDRESS_LEN-1:SRAM_ADDR_LEN+1]};

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_n   = state;
    counter_n = counter;
    case (state)
      IDLE: begin
        if (request) begin
          state_n   = LOW;
          counter_n = '0;
        end
      end
      LOW: begin
        if (last_cycle) begin
          state_n   = HIGH;
          counter_n = '0;
        end else begin
          counter_n = counter + 1'b1;
        end
      end
      HIGH: begin
        if (last_cycle) begin
          state_n   = DONE;
          counter_n = '0;
        end else begin
          counter_n = counter + 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
  // NOTE: every register (including command/data latches) has a reset value; there is no storage array here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      counter   <= '0;
      cmd_wr    <= 1'b0;
      widx_q    <= '0;
      wdata_q   <= '0;
      lo        <= '0;
      read_data <= '0;
    end else begin
      state   <= state_n;
      counter <= counter_n;
      if (state == IDLE && request) begin
        cmd_wr  <= wr_en;
        widx_q  <= offset[SRAM_ADDR_LEN:2];
        wdata_q <= write_data;
      end
      if (state == LOW && last_cycle && !cmd_wr)
        lo <= sram_dq;
      // The high half arrives on the same edge that enters DONE, so take it straight off the bus.
      if (state == HIGH && last_cycle && !cmd_wr)
        read_data <= {sram_dq, lo};
    end
  end

  assign active    = (state == LOW) || (state == HIGH);
  assign sram_we_n = !(active && cmd_wr);
  assign sram_addr = active ? {widx_q, (state == HIGH)} : '0;
  assign dq_out    = (state == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
  assign sram_dq   = sram_we_n ? 16'hzzzz : dq_out;

  assign ready = ((state == IDLE) && !request) || (state == DONE);

endmodule

// File: tb/tb_exe_mem_sram_controller.sv
// Scoreboard bench for exe_mem_sram_controller: two instances (WAIT_CYCLES 1 and 0),
// each with a behavioural 16-bit SRAM on its bus.
module tb_exe_mem_sram_controller;

  localparam int BASE = 1024;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rd_cmd, wr_cmd;
  logic [31:0] addr_cmd, wdata_cmd;
  int          sel;

  logic        rd0, wr0, rd1, wr1;
  logic [31:0] rdata0, rdata1;
  logic        ready0, ready1, we0, we1;
  logic [17:0] addr0, addr1;
  wire  [15:0] dq0, dq1;

  assign rd0 = rd_cmd && (sel == 0);
  assign wr0 = wr_cmd && (sel == 0);
  assign rd1 = rd_cmd && (sel == 1);
  assign wr1 = wr_cmd && (sel == 1);

  exe_mem_sram_controller #(.WAIT_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst), .rd_en(rd0), .wr_en(wr0), .address(addr_cmd),
    .write_data(wdata_cmd), .read_data(rdata0), .ready(ready0),
    .sram_dq(dq0), .sram_addr(addr0), .sram_we_n(we0)
  );

  exe_mem_sram_controller #(.WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .address(addr_cmd),
    .write_data(wdata_cmd), .read_data(rdata1), .ready(ready1),
    .sram_dq(dq1), .sram_addr(addr1), .sram_we_n(we1)
  );

  // Behavioural SRAMs: drive the bus whenever the controller is not writing.
  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];
  initial for (int i = 0; i < 256; i++) begin mem0[i] = '0; mem1[i] = '0; end
  assign dq0 = we0 ? mem0[addr0[7:0]] : 16'hzzzz;
  assign dq1 = we1 ? mem1[addr1[7:0]] : 16'hzzzz;
  always @(posedge clk) begin
    if (!we0) mem0[addr0[7:0]] <= dq0;
    if (!we1) mem1[addr1[7:0]] <= dq1;
  end

  logic [31:0] mon_rdata;
  logic        mon_ready, mon_we;
  logic [17:0] mon_addr;
  logic [15:0] mon_dq;
  always_comb begin
    mon_rdata = (sel == 1) ? rdata1 : rdata0;
    mon_ready = (sel == 1) ? ready1 : ready0;
    mon_we    = (sel == 1) ? we1    : we0;
    mon_addr  = (sel == 1) ? addr1  : addr0;
    mon_dq    = (sel == 1) ? dq1    : dq0;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [17:0] addr;
    logic        we_n;
    logic [15:0] dq;
  } phase_t;

  phase_t      exp_q[$];
  logic [31:0] exp_rdata_q[$];
  int          exp_lat_q[$];
  logic [31:0] model [int];
  logic [31:0] last_rd [2];

  // One complete access on the selected instance; expectations are queued before driving.
  task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input bit drop);
    int          wc   = (sel == 1) ? 0 : 1;
    int          widx = int'((a - BASE) >> 2);
    int          key  = sel * 65536 + widx;
    logic [17:0] base = 18'(widx * 2);
    int          cyc  = 0;
    phase_t      ph;
    for (int h = 0; h < 2; h++)
      for (int k = 0; k <= wc; k++)
        exp_q.push_back('{addr: base | 18'(h), we_n: !wr, dq: (h == 1) ? d[31:16] : d[15:0]});
    exp_lat_q.push_back(2 * wc + 3);
    if (wr) model[key] = d;
    else    last_rd[sel] = model.exists(key) ? model[key] : 32'h0;
    exp_rdata_q.push_back(last_rd[sel]);

    @(negedge clk);
    rd_cmd = rd; wr_cmd = wr; addr_cmd = a; wdata_cmd = d;
    #1 check("req_ready", {31'b0, mon_ready}, 32'h0);
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (mon_ready) break;
      if (exp_q.size() == 0) begin
        check("trace_over", 32'(cyc), 32'(2 * wc + 2));
      end else begin
        ph = exp_q.pop_front();
        check("sram_addr", {14'b0, mon_addr}, {14'b0, ph.addr});
        check("sram_we_n", {31'b0, mon_we}, {31'b0, ph.we_n});
        if (!ph.we_n) check("sram_dq", {16'b0, mon_dq}, {16'b0, ph.dq});
      end
      if (drop && cyc == 1) begin rd_cmd = 1'b0; wr_cmd = 1'b0; end
    end
    check("latency", 32'(cyc), 32'(exp_lat_q.pop_front()));
    check("read_data", mon_rdata, exp_rdata_q.pop_front());
    check("trace_left", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    rd_cmd = 1'b0; wr_cmd = 1'b0;
  endtask

  initial begin
    sel = 0; rst = 1'b0; rd_cmd = 1'b0; wr_cmd = 1'b0; addr_cmd = '0; wdata_cmd = '0;
    last_rd[0] = '0; last_rd[1] = '0;
    #1;
    check("rst_ready", {31'b0, ready0}, 32'h1);
    check("rst_we_n", {31'b0, we0}, 32'h1);
    check("rst_addr", {14'b0, addr0}, 32'h0);
    check("rst_rdata", rdata0, 32'h0);
    @(negedge clk); rst = 1'b1;

    // Idle passthrough
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", {31'b0, ready0}, 32'h1);
      check("idle_we_n", {31'b0, we0}, 32'h1);
    end

    access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b0);
    access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'd1036, 32'h0BADF00D, 1'b0);
    access(1'b0, 1'b1, 32'd1036, 32'h0, 1'b1);       // read dropped during LOW
    access(1'b1, 1'b1, 32'd1024, 32'hCAFEF00D, 1'b0); // write wins, read_data holds
    access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);

    // WAIT_CYCLES=0 instance: back-to-back writes then a read back
    sel = 1;
    access(1'b1, 1'b0, 32'd1024, 32'h11112222, 1'b0);
    access(1'b1, 1'b0, 32'd1032, 32'h33334444, 1'b0);
    access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0);

    // Reset during the HIGH phase of a write with the request still held
    sel = 0;
    @(negedge clk);
    wr_cmd = 1'b1; addr_cmd = 32'd1040; wdata_cmd = 32'h12345678;
    repeat (3) @(negedge clk);
    check("pre_rst_we_n", {31'b0, we0}, 32'h0);
    check("pre_rst_addr", {14'b0, addr0}, 32'd9);
    #2 rst = 1'b0;
    #1;
    check("arst_we_n", {31'b0, we0}, 32'h1);
    check("arst_addr", {14'b0, addr0}, 32'h0);
    check("arst_rdata", rdata0, 32'h0);
    check("arst_ready_held", {31'b0, ready0}, 32'h0);
    wr_cmd = 1'b0;
    #1 check("arst_ready_idle", {31'b0, ready0}, 32'h1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
